// File: rtl/gpio_defs.sv
// Shared register indices and default timing parameters for the GPIO register blocks.
package gpio_defs;

  typedef enum logic [1:0] {
    GPIO_IN_DATA    = 2'd0,
    GPIO_IN_RISE_EN = 2'd1,
    GPIO_IN_FALL_EN = 2'd2,
    GPIO_IN_STATUS  = 2'd3
  } gpio_in_reg_e;

  localparam int GPIO_IN_SYNC_STAGES     = 2;
  localparam int GPIO_IN_DEBOUNCE_CYCLES = 4;

endpackage

// File: rtl/gpio_in_debounce.sv
// One pin: SYNC_STAGES-flop synchronizer, then a level must differ for DEBOUNCE_CYCLES cycles before it becomes stable.
// rise/fall pulse on the same edge stable changes; no backpressure.
module gpio_in_debounce
  import gpio_defs::*;
#(
  parameter int SYNC_STAGES     = GPIO_IN_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = GPIO_IN_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic resetn,
  input  logic pin,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic                   stable_q;
  logic                   sync;
  logic                   accept;

  assign sync   = sync_q[SYNC_STAGES-1];
  assign accept = (sync != stable_q) && (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
      // Any return to the stable level restarts the qualification window.
      if (sync == stable_q) begin
        cnt_q <= '0;
      end else if (accept) begin
        stable_q <= sync;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign stable = stable_q;
  assign rise   = accept & sync;
  assign fall   = accept & ~sync;

endmodule

// File: rtl/gpio_in_ip.sv
// GPIO input block: debounced pins, per-bit edge enables, sticky W1C status and level irq.
// Pin-to-DATA latency SYNC_STAGES+DEBOUNCE_CYCLES edges; zero-latency reads, no backpressure.
module gpio_in_ip
  import gpio_defs::*;
#(
  parameter int WIDTH           = 32,
  parameter int SYNC_STAGES     = GPIO_IN_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = GPIO_IN_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [1:0]       addr,
  input  logic [31:0]      wr_data,
  output logic [31:0]      rd_data,
  input  logic [WIDTH-1:0] gpio_in,
  output logic             irq
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] rise_en_q;
  logic [WIDTH-1:0] fall_en_q;
  logic [WIDTH-1:0] status_q;
  logic [WIDTH-1:0] status_set;
  logic [WIDTH-1:0] status_clr;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    gpio_in_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .resetn (resetn),
      .pin    (gpio_in[i]),
      .stable (stable[i]),
      .rise   (rise[i]),
      .fall   (fall[i])
    );
  end

  always_comb begin
    status_set = (rise & rise_en_q) | (fall & fall_en_q);
    status_clr = '0;
    if (wr_en && (addr == GPIO_IN_STATUS)) begin
      status_clr = wr_data[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
    end else begin
      if (wr_en && (addr == GPIO_IN_RISE_EN)) rise_en_q <= wr_data[WIDTH-1:0];
      if (wr_en && (addr == GPIO_IN_FALL_EN)) fall_en_q <= wr_data[WIDTH-1:0];
      // A new edge in the same cycle as a clear must not be lost.
      status_q <= (status_q & ~status_clr) | status_set;
    end
  end

  always_comb begin
    rd_data = '0;
    if (resetn && rd_en) begin
      case (addr)
        GPIO_IN_DATA:    rd_data = 32'(stable);
        GPIO_IN_RISE_EN: rd_data = 32'(rise_en_q);
        GPIO_IN_FALL_EN: rd_data = 32'(fall_en_q);
        GPIO_IN_STATUS:  rd_data = 32'(status_q);
        default:         rd_data = '0;
      endcase
    end
  end

  assign irq = resetn & (|status_q);

endmodule

// File: tb/tb_gpio_in_ip.sv
// Bench for gpio_in_ip: directed scenarios plus random pins/register traffic against a sample-history model.
module tb_gpio_in_ip;
  localparam int W    = 32;
  localparam int SYNC = 2;
  localparam int DC   = 4;
  localparam int LAT  = SYNC + DC;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [1:0]    addr = '0;
  logic [31:0]   wr_data = '0;
  logic [31:0]   rd_data;
  logic [W-1:0]  gpio_in = '0;
  logic          irq;

  int checks = 0;
  int errors = 0;

  // Model state: pin samples taken on every edge since the last reset edge.
  logic [31:0] hist[$];
  logic [31:0] m_stable = '0;
  logic [31:0] m_rise = '0;
  logic [31:0] m_fall = '0;
  logic [31:0] m_status = '0;

  gpio_in_ip #(.WIDTH(W), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DC)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .wr_en   (wr_en),
    .rd_en   (rd_en),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .gpio_in (gpio_in),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Synchronized level seen by the debouncer just before edge k.
  function automatic logic [31:0] syncv(input int k);
    if (k < SYNC) return '0;
    return hist[k - SYNC];
  endfunction

  task automatic model_edge();
    logic [31:0] set_m;
    logic [31:0] clr_m;
    logic [31:0] s;
    logic [31:0] new_stable;
    logic        all_diff;
    int          t;
    if (!resetn) begin
      m_stable = '0; m_rise = '0; m_fall = '0; m_status = '0;
      hist.delete();
      return;
    end
    t = hist.size();
    set_m = '0;
    new_stable = m_stable;
    for (int i = 0; i < W; i++) begin
      all_diff = 1'b1;
      for (int j = 0; j < DC; j++) begin
        s = syncv(t - j);
        if (s[i] == m_stable[i]) all_diff = 1'b0;
      end
      if (all_diff) begin
        new_stable[i] = ~m_stable[i];
        if (new_stable[i] && m_rise[i]) set_m[i] = 1'b1;
        if (!new_stable[i] && m_fall[i]) set_m[i] = 1'b1;
      end
    end
    clr_m = '0;
    if (wr_en) begin
      case (addr)
        2'd1: m_rise = wr_data;
        2'd2: m_fall = wr_data;
        2'd3: clr_m = wr_data;
        default: ;
      endcase
    end
    m_status = (m_status & ~clr_m) | set_m;
    m_stable = new_stable;
    hist.push_back(gpio_in);
  endtask

  function automatic logic [31:0] exp_rd();
    if (!resetn || !rd_en) return '0;
    case (addr)
      2'd0: return m_stable;
      2'd1: return m_rise;
      2'd2: return m_fall;
      default: return m_status;
    endcase
  endfunction

  // Inputs are set by the caller after a negedge; check before the edge, then advance one clock.
  task automatic step();
    #1;
    check_eq("rd_data", rd_data, exp_rd());
    check_eq("irq", 32'(irq), 32'((resetn == 1'b1) && (m_status != 0)));
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    wr_en = 1'b1; addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  initial begin
    int n;

    repeat (3) step();
    resetn = 1'b1;
    for (int a = 0; a < 4; a++) begin
      rd_en = 1'b1; addr = 2'(a);
      step();
    end
    rd_en = 1'b0;
    step();

    // Rising edge on bit 0 with exact latency.
    wr(2'd1, 32'h1);
    gpio_in[0] = 1'b1;
    rd_en = 1'b1; addr = 2'd0;
    n = 0;
    while (n < 20) begin
      step();
      n++;
      if (rd_data[0] === 1'b1) break;
    end
    check_eq("lat_bit0", 32'(n), 32'(LAT));
    addr = 2'd3;
    #1;
    check_eq("status_bit0", rd_data, 32'h1);
    check_eq("irq_bit0", 32'(irq), 32'h1);

    // Short glitch on bit 3 must be discarded.
    gpio_in[3] = 1'b1;
    repeat (3) step();
    gpio_in[3] = 1'b0;
    repeat (10) step();
    addr = 2'd0;
    #1;
    check_eq("glitch_data", rd_data, 32'h1);

    // Falling edge on bit 3, then W1C behaviour.
    wr(2'd3, 32'h1);
    wr(2'd2, 32'h8);
    gpio_in[3] = 1'b1;
    repeat (10) step();
    gpio_in[3] = 1'b0;
    repeat (10) step();
    rd_en = 1'b1; addr = 2'd3;
    #1;
    check_eq("fall_status", rd_data, 32'h8);
    wr(2'd3, 32'h8);
    rd_en = 1'b1; addr = 2'd3;
    #1;
    check_eq("w1c_clear", rd_data, 32'h0);
    wr(2'd3, 32'h0);
    rd_en = 1'b1; addr = 2'd3;
    step();

    // Fall accepted on the same edge as a clear of that bit.
    gpio_in[3] = 1'b1;
    repeat (10) step();
    gpio_in[3] = 1'b0;
    repeat (LAT - 1) step();
    wr(2'd3, 32'h8);
    rd_en = 1'b1; addr = 2'd3;
    #1;
    check_eq("set_wins", 32'(rd_data[3]), 32'h1);
    wr(2'd3, 32'hffff_ffff);

    // Reset in the middle of a bit 5 debounce.
    wr(2'd1, 32'h20);
    gpio_in[5] = 1'b1;
    repeat (3) step();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    rd_en = 1'b1; addr = 2'd1;
    #1;
    check_eq("rst_rise_en", rd_data, 32'h0);
    wr(2'd1, 32'h20);
    rd_en = 1'b1;
    repeat (12) step();
    addr = 2'd0;
    #1;
    check_eq("rst_data", rd_data, 32'h21);
    addr = 2'd3;
    #1;
    check_eq("rst_status", rd_data, 32'h20);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      gpio_in = gpio_in ^ ($urandom & $urandom & $urandom);
      wr_en   = ($urandom_range(0, 7) == 0);
      rd_en   = $urandom_range(0, 1) == 1;
      addr    = 2'($urandom_range(0, 3));
      wr_data = ($urandom_range(0, 1) == 1) ? $urandom : ($urandom & $urandom & $urandom);
      resetn  = ($urandom_range(0, 499) != 0);
      step();
    end
    resetn = 1'b1;
    wr_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
